// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package teclado_pkg;

  localparam int unsigned N_COLS = 4;
  localparam int unsigned N_ROWS = 4;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} scan_state_t;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {NONE, ONE, MULTI} scan_class_t;

  // Key code layout: row index in the upper bits, column index in the lower bits.
  function automatic key_code_t make_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/module_sync_rows.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles high (no key).
module module_sync_rows #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/module_teclado_ctrl.sv
// 4x4 keypad scanner: one-hot column drive, per-scan classification,
// whole-scan debounce and a valid/ready key event output with overrun flag.
module module_teclado_ctrl
  import teclado_pkg::*;
#(
  parameter int unsigned WAIT_TIME      = 27000,
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned ROWS           = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row,
  output logic [WIDTH-1:0] col,
  output logic [3:0]       key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             overrun
);

  localparam int unsigned DWELL_W = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam bit          DS_ONE  = (DEBOUNCE_SCANS == 1);

  logic [ROWS-1:0]    row_s;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         col_idx;
  logic               sample_c;
  logic               scan_end_c;

  module_sync_rows #(.W(ROWS)) u_sync_rows (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign sample_c   = (dwell == DWELL_W'(WAIT_TIME - 1));
  assign scan_end_c = sample_c && (col_idx == 2'(N_COLS - 1));

  // Column dwell and rotation; col is rotated in lockstep with col_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= '0;
      col     <= {{(WIDTH-1){1'b1}}, 1'b0};
    end else if (sample_c) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= {col[WIDTH-2:0], col[WIDTH-1]};
    end else begin
      dwell   <= dwell + DWELL_W'(1);
    end
  end

  // Hits on the active column at the sample point.
  logic [2:0] col_hits_c;
  logic [1:0] col_row_c;

  always_comb begin
    col_hits_c = '0;
    col_row_c  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s[r]) begin
        col_hits_c = col_hits_c + 3'd1;
        col_row_c  = 2'(r);
      end
    end
  end

  // Running hit count (saturating at 2) and last hit code across the scan.
  logic [1:0]  acc_cnt;
  key_code_t   acc_code;
  logic [2:0]  tot_c;
  key_code_t   code_c;
  scan_class_t cls_c;

  assign tot_c  = 3'(acc_cnt) + col_hits_c;
  assign code_c = (col_hits_c == 3'd1) ? make_code(col_row_c, col_idx) : acc_code;

  always_comb begin
    cls_c = MULTI;
    if (tot_c == 3'd0)      cls_c = NONE;
    else if (tot_c == 3'd1) cls_c = ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (scan_end_c) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample_c) begin
      acc_cnt  <= (tot_c >= 3'd2) ? 2'd2 : tot_c[1:0];
      acc_code <= code_c;
    end
  end

  // Debounce FSM, evaluated once per scan end.
  scan_state_t state, state_nxt;
  key_code_t   cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc_c;
  logic        emit_c;

  assign cnt_inc_c = cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    emit_c    = 1'b0;
    if (scan_end_c) begin
      unique case (state)
        IDLE: begin
          if (cls_c == ONE) begin
            cand_nxt = code_c;
            cnt_nxt  = CNT_W'(1);
            if (DS_ONE) begin
              emit_c    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (cls_c == ONE && code_c == cand) begin
            cnt_nxt = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEBOUNCE_SCANS)) begin
              emit_c    = 1'b1;
              state_nxt = HELD;
            end
          end else if (cls_c == ONE) begin
            cand_nxt = code_c;
            cnt_nxt  = CNT_W'(1);
          end else begin
            state_nxt = IDLE;
          end
        end
        HELD: begin
          // A different single key while held is a rollover; it waits for a release.
          if (cls_c == NONE) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = DS_ONE ? IDLE : REL_CHK;
          end
        end
        REL_CHK: begin
          if (cls_c == NONE) begin
            cnt_nxt = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEBOUNCE_SCANS)) state_nxt = IDLE;
          end else begin
            state_nxt = HELD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Event output handshake; an accept in the same cycle makes room for a new emit.
  logic accept_c;
  assign accept_c = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_held <= (state_nxt == HELD) || (state_nxt == REL_CHK);
      if (emit_c) begin
        if (!key_valid || accept_c) begin
          key_code  <= code_c;
          key_valid <= 1'b1;
          if (accept_c) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept_c) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule
